// File: rtl/pipelined_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_controller
//  Purpose  : RV32I control decoder with registered EX / MEM / WB control
//             bundles. The ID stage decodes opcode/funct7 into the EX
//             register. Supports a global stall, a branch flush of the ID
//             instruction and bubble insertion. When MULDIV_EN is set, an
//             optional mul/div op holds EX for MULDIV_LAT cycles and
//             back-pressures ID.
//  Ports    : i_clk, i_rst (async, active high)
//             i_valid, i_opcode, i_funct7      - ID instruction
//             i_stall, i_flush                 - pipeline control
//             o_ready                          - ID may advance
//             o_ex_*                           - EX control bundle
//             o_mem_valid/o_mem_w/o_mem_mem2reg
//             o_wb_valid/o_wb_reg_w
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_controller #(
    parameter int ALUOP_W    = 4,
    parameter int MULDIV_EN  = 0,
    parameter int MULDIV_LAT = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [6:0]         i_opcode,
    input  logic [6:0]         i_funct7,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_ready,
    output logic               o_ex_valid,
    output logic [ALUOP_W-1:0] o_ex_aluOp,
    output logic               o_ex_exec_a,
    output logic               o_ex_exec_b,
    output logic               o_ex_bra,
    output logic               o_ex_jmp,
    output logic               o_ex_muldiv,
    output logic               o_ex_illegal,
    output logic               o_mem_valid,
    output logic               o_mem_w,
    output logic               o_mem_mem2reg,
    output logic               o_wb_valid,
    output logic               o_wb_reg_w
);

    localparam logic [6:0] c_OP_R       = 7'b0110011;
    localparam logic [6:0] c_OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] c_OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_S       = 7'b0100011;
    localparam logic [6:0] c_OP_B       = 7'b1100011;
    localparam logic [6:0] c_OP_J       = 7'b1101111;
    localparam logic [6:0] c_OP_I_JUMP  = 7'b1100111;
    localparam logic [6:0] c_OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_I_SYS   = 7'b1110011;
    localparam logic [6:0] c_OP_I_FENCE = 7'b0001111;
    localparam logic [6:0] c_F7_MULDIV  = 7'b0000001;

    localparam int                 c_CNT_W    = $clog2(MULDIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MULDIV_LAT - 1);

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] aluop;
        logic               exec_a;
        logic               exec_b;
        logic               bra;
        logic               jmp;
        logic               muldiv;
        logic               illegal;
        logic               mem_w;
        logic               reg_w;
        logic               mem2reg;
    } ex_ctrl_t;

    ex_ctrl_t           w_dec;
    ex_ctrl_t           w_ex_next;
    logic [3:0]         w_alu4;
    logic               w_busy;

    ex_ctrl_t           r_ex;
    logic               r_mem_valid;
    logic               r_mem_w;
    logic               r_mem_mem2reg;
    logic               r_mem_reg_w;
    logic               r_wb_valid;
    logic               r_wb_reg_w;
    logic [c_CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec       = '0;
        w_alu4      = 4'b0000;
        w_dec.valid = 1'b1;
        case (i_opcode)
            c_OP_R: begin
                w_alu4       = 4'b0010;
                w_dec.reg_w  = 1'b1;
                w_dec.muldiv = (MULDIV_EN != 0) && (i_funct7 == c_F7_MULDIV);
            end
            c_OP_I_ARITH: begin
                w_alu4       = 4'b0011;
                w_dec.exec_b = 1'b1;
                w_dec.reg_w  = 1'b1;
            end
            c_OP_I_LOAD: begin
                w_dec.exec_b  = 1'b1;
                w_dec.reg_w   = 1'b1;
                w_dec.mem2reg = 1'b1;
            end
            c_OP_S: begin
                w_dec.exec_b = 1'b1;
                w_dec.mem_w  = 1'b1;
            end
            c_OP_B: begin
                w_alu4    = 4'b0001;
                w_dec.bra = 1'b1;
            end
            c_OP_J: begin
                w_dec.exec_a = 1'b1;
                w_dec.exec_b = 1'b1;
                w_dec.reg_w  = 1'b1;
                w_dec.jmp    = 1'b1;
            end
            c_OP_I_JUMP: begin
                w_dec.exec_b = 1'b1;
                w_dec.reg_w  = 1'b1;
                w_dec.jmp    = 1'b1;
            end
            c_OP_U_LUI: begin
                w_alu4       = 4'b0100;
                w_dec.exec_b = 1'b1;
                w_dec.reg_w  = 1'b1;
            end
            c_OP_U_AUIPC: begin
                w_dec.exec_a = 1'b1;
                w_dec.exec_b = 1'b1;
                w_dec.reg_w  = 1'b1;
            end
            c_OP_I_SYS, c_OP_I_FENCE: begin
                // legal, no datapath control
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.aluop = ALUOP_W'(w_alu4);
    end

    // An invalid or flushed ID slot enters EX as an all-zero bubble.
    assign w_ex_next = (i_valid && !i_flush) ? w_dec : '0;

    // Counter is loaded with LAT-1 on entry, so EX stays put while it is
    // non-zero and releases in the cycle it reads zero: LAT cycles total.
    assign w_busy  = (r_cnt != '0);
    assign o_ready = ~i_stall & ~w_busy;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex          <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_w       <= 1'b0;
            r_mem_mem2reg <= 1'b0;
            r_mem_reg_w   <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_reg_w    <= 1'b0;
            r_cnt         <= '0;
        end else if (!i_stall) begin
            r_wb_valid <= r_mem_valid;
            r_wb_reg_w <= r_mem_reg_w;
            if (w_busy) begin
                // EX holds; MEM gets a bubble; flush has no effect here
                r_mem_valid   <= 1'b0;
                r_mem_w       <= 1'b0;
                r_mem_mem2reg <= 1'b0;
                r_mem_reg_w   <= 1'b0;
                r_cnt         <= r_cnt - c_CNT_W'(1);
            end else begin
                r_mem_valid   <= r_ex.valid;
                r_mem_w       <= r_ex.mem_w;
                r_mem_mem2reg <= r_ex.mem2reg;
                r_mem_reg_w   <= r_ex.reg_w;
                r_ex          <= w_ex_next;
                r_cnt         <= w_ex_next.muldiv ? c_CNT_LOAD : '0;
            end
        end
    end

    assign o_ex_valid    = r_ex.valid;
    assign o_ex_aluOp    = r_ex.aluop;
    assign o_ex_exec_a   = r_ex.exec_a;
    assign o_ex_exec_b   = r_ex.exec_b;
    assign o_ex_bra      = r_ex.bra;
    assign o_ex_jmp      = r_ex.jmp;
    assign o_ex_muldiv   = r_ex.muldiv;
    assign o_ex_illegal  = r_ex.illegal;
    assign o_mem_valid   = r_mem_valid;
    assign o_mem_w       = r_mem_w;
    assign o_mem_mem2reg = r_mem_mem2reg;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_reg_w    = r_wb_reg_w;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_controller
//  Purpose  : Self-checking bench for pipelined_controller. Two instances
//             share one stimulus stream:
//               u_dut0 : ALUOP_W=6, MULDIV_EN=0, MULDIV_LAT=32
//               u_dut1 : ALUOP_W=4, MULDIV_EN=1, MULDIV_LAT=4
//             Each is compared every cycle against a transaction-level
//             model of the three stage slots.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       stall;
    logic       flush;

    always #5 clk = ~clk;

    // ---------------- DUT 0 ----------------
    logic       rdy0, exv0, ea0, eb0, bra0, jmp0, md0, ill0, mv0, mw0, m2r0, wv0, wrw0;
    logic [5:0] alu0;
    pipelined_controller #(.ALUOP_W(6), .MULDIV_EN(0), .MULDIV_LAT(32)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_opcode(opcode), .i_funct7(funct7),
        .i_stall(stall), .i_flush(flush), .o_ready(rdy0), .o_ex_valid(exv0),
        .o_ex_aluOp(alu0), .o_ex_exec_a(ea0), .o_ex_exec_b(eb0), .o_ex_bra(bra0),
        .o_ex_jmp(jmp0), .o_ex_muldiv(md0), .o_ex_illegal(ill0), .o_mem_valid(mv0),
        .o_mem_w(mw0), .o_mem_mem2reg(m2r0), .o_wb_valid(wv0), .o_wb_reg_w(wrw0)
    );

    // ---------------- DUT 1 ----------------
    logic       rdy1, exv1, ea1, eb1, bra1, jmp1, md1, ill1, mv1, mw1, m2r1, wv1, wrw1;
    logic [3:0] alu1;
    pipelined_controller #(.ALUOP_W(4), .MULDIV_EN(1), .MULDIV_LAT(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_opcode(opcode), .i_funct7(funct7),
        .i_stall(stall), .i_flush(flush), .o_ready(rdy1), .o_ex_valid(exv1),
        .o_ex_aluOp(alu1), .o_ex_exec_a(ea1), .o_ex_exec_b(eb1), .o_ex_bra(bra1),
        .o_ex_jmp(jmp1), .o_ex_muldiv(md1), .o_ex_illegal(ill1), .o_mem_valid(mv1),
        .o_mem_w(mw1), .o_mem_mem2reg(m2r1), .o_wb_valid(wv1), .o_wb_reg_w(wrw1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [3:0] alu;
        logic       a, b, bra, jmp, md, ill, mw, rw, m2r;
    } bnd_t;

    localparam int c_LAT[2] = '{32, 4};
    localparam bit c_EN[2]  = '{1'b0, 1'b1};

    bnd_t m_ex[2];
    bnd_t m_mem[2];
    bnd_t m_wb[2];
    int   m_left[2];   // cycles the EX instruction still has to spend in EX

    int n_total = 0;
    int n_bad   = 0;
    int md_cnt;
    int nrdy_cnt;

    logic [6:0] ops[12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                            7'b0010111, 7'b1110011, 7'b0001111, 7'h7F};

    // Decode table: {aluOp, a, b, mem_w, reg_w, mem2reg, bra, jmp}
    function automatic bnd_t ref_decode(input logic [6:0] op, input logic [6:0] f7, input bit en);
        bnd_t d;
        logic [10:0] row;
        d     = '0;
        d.v   = 1'b1;
        row   = 11'b0;
        case (op)
            7'b0110011: row = 11'b0010_0_0_0_1_0_0_0;
            7'b0010011: row = 11'b0011_0_1_0_1_0_0_0;
            7'b0000011: row = 11'b0000_0_1_0_1_1_0_0;
            7'b0100011: row = 11'b0000_0_1_1_0_0_0_0;
            7'b1100011: row = 11'b0001_0_0_0_0_0_1_0;
            7'b1101111: row = 11'b0000_1_1_0_1_0_0_1;
            7'b1100111: row = 11'b0000_0_1_0_1_0_0_1;
            7'b0110111: row = 11'b0100_0_1_0_1_0_0_0;
            7'b0010111: row = 11'b0000_1_1_0_1_0_0_0;
            7'b1110011, 7'b0001111: row = 11'b0;
            default: d.ill = 1'b1;
        endcase
        {d.alu, d.a, d.b, d.mw, d.rw, d.m2r, d.bra, d.jmp} = row;
        d.md = en && (op == 7'b0110011) && (f7 == 7'b0000001);
        return d;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_left[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_left[k] = 0;
        end else if (!stall) begin
            m_wb[k] = m_mem[k];
            if (m_ex[k].md && m_left[k] > 1) begin
                m_left[k] = m_left[k] - 1;
                m_mem[k]  = '0;
            end else begin
                m_mem[k]  = m_ex[k];
                m_ex[k]   = (valid && !flush) ? ref_decode(opcode, funct7, c_EN[k]) : '0;
                m_left[k] = m_ex[k].md ? c_LAT[k] : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [6:0] op, input logic [6:0] f7,
                         input bit st, input bit fl);
        valid = v; opcode = op; funct7 = f7; stall = st; flush = fl;
    endtask

    // Compare both DUTs against the model, then advance one clock.
    task automatic step_cycle();
        logic [31:0] obs, exp;
        bnd_t e, m, w;
        #1;
        if (rst) model_clear();   // asynchronous clear
        e = m_ex[0]; m = m_mem[0]; w = m_wb[0];
        obs = 32'({exv0, alu0, ea0, eb0, bra0, jmp0, md0, ill0, mv0, mw0, m2r0, wv0, wrw0});
        exp = 32'({e.v, 2'b00, e.alu, e.a, e.b, e.bra, e.jmp, e.md, e.ill, m.v, m.mw, m.m2r, w.v, w.rw});
        check("dut0_stages", obs, exp);
        check("dut0_ready", 32'(rdy0), 32'(!stall && !(e.md && m_left[0] > 1)));
        e = m_ex[1]; m = m_mem[1]; w = m_wb[1];
        obs = 32'({exv1, alu1, ea1, eb1, bra1, jmp1, md1, ill1, mv1, mw1, m2r1, wv1, wrw1});
        exp = 32'({e.v, e.alu, e.a, e.b, e.bra, e.jmp, e.md, e.ill, m.v, m.mw, m.m2r, w.v, w.rw});
        check("dut1_stages", obs, exp);
        check("dut1_ready", 32'(rdy1), 32'(!stall && !(e.md && m_left[1] > 1)));
        if (md1) md_cnt++;
        if (!rdy1 && !stall) nrdy_cnt++;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 7'h00, 7'h00, 0, 0);
        model_clear();

        // Reset for 3 cycles, then first R op
        repeat (3) step_cycle();
        rst = 1'b0;
        drive(1, 7'b0110011, 7'h00, 0, 0);
        step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        #1;
        check("first_r_alu", 32'(alu1), 32'h2);
        check("first_r_alu_zext", 32'(alu0), 32'h2);
        step_cycle();
        step_cycle();
        #1;
        check("first_r_wb_reg_w", 32'(wrw1), 32'h1);
        step_cycle();

        // Opcode sweep, back-to-back
        foreach (ops[i]) begin
            drive(1, ops[i], 7'h00, 0, 0);
            step_cycle();
        end
        drive(0, 7'h00, 7'h00, 0, 0);
        #1;
        check("sweep_illegal", 32'({exv1, ill1, alu1}), 32'({1'b1, 1'b1, 4'h0}));
        repeat (3) step_cycle();

        // Load then store
        drive(1, 7'b0000011, 7'h00, 0, 0); step_cycle();
        drive(1, 7'b0100011, 7'h00, 0, 0); step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        repeat (4) step_cycle();

        // Flush: B in EX, I_ARITH in ID
        drive(1, 7'b1100011, 7'h00, 0, 0); step_cycle();
        drive(1, 7'b0010011, 7'h00, 0, 1); step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        #1;
        check("flush_ex_valid", 32'({exv1, mv1, mw1, m2r1}), 32'b0100);
        repeat (3) step_cycle();

        // Stall with three live stages
        drive(1, 7'b0110011, 7'h00, 0, 0); step_cycle();
        drive(1, 7'b0000011, 7'h00, 0, 0); step_cycle();
        drive(1, 7'b0100011, 7'h00, 0, 0); step_cycle();
        drive(1, 7'b0010011, 7'h00, 1, 0);
        repeat (4) step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        repeat (4) step_cycle();

        // Mul/div, no stall: 4 EX cycles, 3 not-ready cycles
        drive(1, 7'b0110011, 7'b0000001, 0, 0); step_cycle();
        drive(1, 7'b0010011, 7'h00, 0, 0);
        md_cnt = 0; nrdy_cnt = 0;
        repeat (8) step_cycle();
        check("md_occupancy", 32'(md_cnt), 32'd4);
        check("md_not_ready", 32'(nrdy_cnt), 32'd3);

        // Mul/div with a 2-cycle stall mid-op: 6 EX cycles
        drive(1, 7'b0110011, 7'b0000001, 0, 0); step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        md_cnt = 0; nrdy_cnt = 0;
        step_cycle();
        drive(0, 7'h00, 7'h00, 1, 0);
        repeat (2) step_cycle();
        drive(0, 7'h00, 7'h00, 0, 0);
        repeat (8) step_cycle();
        check("md_stall_occupancy", 32'(md_cnt), 32'd6);
        check("md_stall_not_ready", 32'(nrdy_cnt), 32'd3);

        // Async reset mid mul/div, asserted between clock edges
        drive(1, 7'b0110011, 7'b0000001, 0, 0); step_cycle();
        drive(1, 7'b0000011, 7'h00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              32'({exv1, md1, mv1, wv1, exv0, mv0, wv0}), 32'h0);
        check("async_rst_ready", 32'(rdy1), 32'h1);
        repeat (3) step_cycle();
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [6:0] op, f7;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            f7 = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'($urandom);
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 85, op, f7,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
            step_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
